// File: rtl/lru_cache_controller.sv
// 4-way set-associative write-back/write-allocate cache tag controller with
// true-LRU ages held in a single synchronous-read set RAM, plus statistics.
module lru_cache_controller #(
    parameter int TAG_W   = 17,
    parameter int INDEX_W = 11,
    parameter int CNT_W   = 32
) (
    input  logic               clk_sd,
    input  logic               rst,
    input  logic               LRULineReady,
    input  logic [TAG_W-1:0]   LRUTag,
    input  logic [INDEX_W-1:0] LRUIndex,
    input  logic               LRULoadStore,
    output logic               busy,
    output logic               resultValid,
    output logic               lastHit,
    output logic [CNT_W-1:0]   hitCount,
    output logic [CNT_W-1:0]   missCount,
    output logic [CNT_W-1:0]   loadCount,
    output logic [CNT_W-1:0]   storeCount,
    output logic [CNT_W-1:0]   evictCount,
    output logic [CNT_W-1:0]   writebackCount,
    output logic [CNT_W-1:0]   dropCount
);

    localparam int NSETS = 2 ** INDEX_W;

    typedef struct packed {
        logic             valid;
        logic             dirty;
        logic [TAG_W-1:0] tag;
        logic [1:0]       age;
    } way_t;

    typedef way_t [3:0] set_t;

    typedef enum logic [2:0] {INIT, IDLE, READ, COMPARE, WRITE} state_e;

    state_e             state_q, state_d;
    logic [INDEX_W-1:0] init_idx_q;
    logic [TAG_W-1:0]   req_tag_q;
    logic [INDEX_W-1:0] req_idx_q;
    logic               req_st_q;
    set_t               rd_set_q;
    logic [1:0]         way_q;
    logic               hit_q;
    logic               last_hit_q;
    logic [CNT_W-1:0]   hit_cnt_q, miss_cnt_q, load_cnt_q, store_cnt_q;
    logic [CNT_W-1:0]   evict_cnt_q, wb_cnt_q, drop_cnt_q;

    set_t               mem [NSETS];

    logic               accept;
    logic               hit;
    logic [1:0]         hit_way;
    logic [1:0]         victim;
    logic               victim_found;
    set_t               upd_set;
    set_t               init_set;
    logic               evict;
    logic               writeback;
    logic               we;
    logic [INDEX_W-1:0] wr_addr;
    set_t               wr_data;

    // State register
    always_ff @(posedge clk_sd) begin
        if (rst) state_q <= INIT;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT:    if (init_idx_q == INDEX_W'(NSETS - 1)) state_d = IDLE;
            IDLE:    if (LRULineReady) state_d = READ;
            READ:    state_d = COMPARE;
            COMPARE: state_d = WRITE;
            WRITE:   state_d = IDLE;
            default: state_d = INIT;
        endcase
    end

    // Outputs
    always_comb begin
        busy        = (state_q != IDLE);
        resultValid = (state_q == WRITE);
    end

    assign accept = (state_q == IDLE) && LRULineReady;

    always_ff @(posedge clk_sd) begin
        if (rst)                   init_idx_q <= '0;
        else if (state_q == INIT)  init_idx_q <= init_idx_q + INDEX_W'(1);
    end

    always_ff @(posedge clk_sd) begin
        if (accept) begin
            req_tag_q <= LRUTag;
            req_idx_q <= LRUIndex;
            req_st_q  <= LRULoadStore;
        end
    end

    // Set RAM: one synchronous read port, one write port
    always_ff @(posedge clk_sd) begin
        if (accept) rd_set_q <= mem[LRUIndex];
        if (we)     mem[wr_addr] <= wr_data;
    end

    // Hit detection and victim choice on the set read back
    always_comb begin
        hit          = 1'b0;
        hit_way      = 2'd0;
        victim       = 2'd0;
        victim_found = 1'b0;
        for (int unsigned w = 0; w < 4; w++) begin
            if (rd_set_q[w].valid && rd_set_q[w].tag == req_tag_q) begin
                hit     = 1'b1;
                hit_way = 2'(w);
            end
        end
        for (int unsigned w = 0; w < 4; w++) begin
            if (!rd_set_q[w].valid && !victim_found) begin
                victim       = 2'(w);
                victim_found = 1'b1;
            end
        end
        if (!victim_found) begin
            for (int unsigned w = 0; w < 4; w++) begin
                if (rd_set_q[w].age == 2'd3) victim = 2'(w);
            end
        end
    end

    always_ff @(posedge clk_sd) begin
        if (state_q == COMPARE) begin
            hit_q <= hit;
            way_q <= hit ? hit_way : victim;
        end
    end

    // Updated set: accessed way becomes youngest, younger ways age by one
    always_comb begin
        upd_set = rd_set_q;
        for (int unsigned w = 0; w < 4; w++) begin
            if (2'(w) == way_q) begin
                upd_set[w].valid = 1'b1;
                upd_set[w].tag   = req_tag_q;
                upd_set[w].dirty = hit_q ? (rd_set_q[w].dirty | req_st_q) : req_st_q;
                upd_set[w].age   = 2'd0;
            end else if (rd_set_q[w].age < rd_set_q[way_q].age) begin
                upd_set[w].age = rd_set_q[w].age + 2'd1;
            end
        end
        evict     = !hit_q && rd_set_q[way_q].valid;
        writeback = evict && rd_set_q[way_q].dirty;
    end

    always_comb begin
        for (int unsigned w = 0; w < 4; w++) begin
            init_set[w].valid = 1'b0;
            init_set[w].dirty = 1'b0;
            init_set[w].tag   = '0;
            init_set[w].age   = 2'(w);
        end
    end

    // Writes are suppressed while rst is high so an aborted access leaves no trace
    always_comb begin
        we      = !rst && (state_q == INIT || state_q == WRITE);
        wr_addr = (state_q == INIT) ? init_idx_q : req_idx_q;
        wr_data = (state_q == INIT) ? init_set : upd_set;
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && v != '1) ? v + CNT_W'(1) : v;
    endfunction

    always_ff @(posedge clk_sd) begin
        if (rst) begin
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            load_cnt_q  <= '0;
            store_cnt_q <= '0;
            evict_cnt_q <= '0;
            wb_cnt_q    <= '0;
            drop_cnt_q  <= '0;
            last_hit_q  <= 1'b0;
        end else begin
            if (state_q == WRITE) begin
                hit_cnt_q   <= sat_inc(hit_cnt_q, hit_q);
                miss_cnt_q  <= sat_inc(miss_cnt_q, !hit_q);
                load_cnt_q  <= sat_inc(load_cnt_q, !req_st_q);
                store_cnt_q <= sat_inc(store_cnt_q, req_st_q);
                evict_cnt_q <= sat_inc(evict_cnt_q, evict);
                wb_cnt_q    <= sat_inc(wb_cnt_q, writeback);
                last_hit_q  <= hit_q;
            end
            drop_cnt_q <= sat_inc(drop_cnt_q, LRULineReady && (state_q != IDLE));
        end
    end

    assign lastHit        = last_hit_q;
    assign hitCount       = hit_cnt_q;
    assign missCount      = miss_cnt_q;
    assign loadCount      = load_cnt_q;
    assign storeCount     = store_cnt_q;
    assign evictCount     = evict_cnt_q;
    assign writebackCount = wb_cnt_q;
    assign dropCount      = drop_cnt_q;

endmodule

// File: tb/tb_lru_cache_controller.sv
// Self-checking bench: directed vector table, corner sequences and random
// traffic against a recency-list cache model; small instance for saturation.
module tb_lru_cache_controller;

    logic        clk;
    logic        rst;
    logic        LRULineReady;
    logic [16:0] LRUTag;
    logic [10:0] LRUIndex;
    logic        LRULoadStore;
    logic        busy, resultValid, lastHit;
    logic [31:0] hitCount, missCount, loadCount, storeCount;
    logic [31:0] evictCount, writebackCount, dropCount;

    logic        s_rst, s_rdy, s_ls;
    logic [3:0]  s_tag;
    logic [1:0]  s_idx;
    logic        s_busy, s_rv, s_last;
    logic [1:0]  s_hit, s_miss, s_load, s_store, s_evict, s_wb, s_drop;

    int errors = 0;
    int checks = 0;

    lru_cache_controller dut (
        .clk_sd(clk), .rst(rst), .LRULineReady(LRULineReady), .LRUTag(LRUTag),
        .LRUIndex(LRUIndex), .LRULoadStore(LRULoadStore), .busy(busy),
        .resultValid(resultValid), .lastHit(lastHit), .hitCount(hitCount),
        .missCount(missCount), .loadCount(loadCount), .storeCount(storeCount),
        .evictCount(evictCount), .writebackCount(writebackCount), .dropCount(dropCount)
    );

    lru_cache_controller #(.TAG_W(4), .INDEX_W(2), .CNT_W(2)) sdut (
        .clk_sd(clk), .rst(s_rst), .LRULineReady(s_rdy), .LRUTag(s_tag),
        .LRUIndex(s_idx), .LRULoadStore(s_ls), .busy(s_busy),
        .resultValid(s_rv), .lastHit(s_last), .hitCount(s_hit),
        .missCount(s_miss), .loadCount(s_load), .storeCount(s_store),
        .evictCount(s_evict), .writebackCount(s_wb), .dropCount(s_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference model: per set, way contents plus a recency list (index 0 = most recent)
    bit          m_valid [2048][4];
    bit          m_dirty [2048][4];
    logic [16:0] m_tag   [2048][4];
    int          m_order [2048][4];
    longint unsigned m_hit, m_miss, m_load, m_store, m_evict, m_wb, m_drop;

    function automatic longint unsigned sat(input longint unsigned x);
        return (x < 64'hFFFF_FFFF) ? x + 1 : x;
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < 2048; s++)
            for (int k = 0; k < 4; k++) begin
                m_valid[s][k] = 0; m_dirty[s][k] = 0; m_tag[s][k] = '0; m_order[s][k] = k;
            end
        m_hit = 0; m_miss = 0; m_load = 0; m_store = 0; m_evict = 0; m_wb = 0; m_drop = 0;
    endfunction

    function automatic void model_access(input logic [16:0] tag, input int idx, input bit ls,
                                         output bit h, output bit e, output bit wb);
        int w = -1;
        int p = 0;
        h = 0; e = 0; wb = 0;
        for (int k = 0; k < 4; k++)
            if (m_valid[idx][k] && m_tag[idx][k] == tag) w = k;
        if (w >= 0) begin
            h = 1;
            if (ls) m_dirty[idx][w] = 1;
        end else begin
            for (int k = 0; k < 4; k++)
                if (!m_valid[idx][k] && w < 0) w = k;
            if (w < 0) w = m_order[idx][3];
            e  = m_valid[idx][w];
            wb = m_valid[idx][w] && m_dirty[idx][w];
            m_valid[idx][w] = 1; m_tag[idx][w] = tag; m_dirty[idx][w] = ls;
        end
        for (int k = 0; k < 4; k++) if (m_order[idx][k] == w) p = k;
        for (int k = p; k > 0; k--) m_order[idx][k] = m_order[idx][k-1];
        m_order[idx][0] = w;
        if (h) m_hit = sat(m_hit); else m_miss = sat(m_miss);
        if (ls) m_store = sat(m_store); else m_load = sat(m_load);
        if (e) m_evict = sat(m_evict);
        if (wb) m_wb = sat(m_wb);
    endfunction

    task automatic chk_counters(input string tagname);
        chk({tagname, ".hit"},   hitCount,       m_hit);
        chk({tagname, ".miss"},  missCount,      m_miss);
        chk({tagname, ".load"},  loadCount,      m_load);
        chk({tagname, ".store"}, storeCount,     m_store);
        chk({tagname, ".evict"}, evictCount,     m_evict);
        chk({tagname, ".wb"},    writebackCount, m_wb);
        chk({tagname, ".drop"},  dropCount,      m_drop);
    endtask

    task automatic access(input logic [16:0] tag, input logic [10:0] idx, input bit ls,
                          input bit drop_pulse);
        int lat;
        bit mh, me, mw;
        @(negedge clk);
        LRUTag = tag; LRUIndex = idx; LRULoadStore = ls; LRULineReady = 1'b1;
        @(posedge clk); #1;
        if (drop_pulse) LRUTag = tag ^ 17'h1;
        else            LRULineReady = 1'b0;
        lat = 1;
        while (!resultValid && lat < 8) begin
            @(posedge clk); #1;
            LRULineReady = 1'b0;
            lat++;
        end
        chk("latency", lat, 3);
        model_access(tag, int'(idx), ls, mh, me, mw);
        if (drop_pulse) m_drop = sat(m_drop);
        @(posedge clk); #1;
        chk("rv_pulse", resultValid, 1'b0);
        chk("busy_after", busy, 1'b0);
        chk("lastHit", lastHit, mh);
        chk_counters("acc");
    endtask

    task automatic release_reset(input bit init_drop);
        int n = 0;
        @(negedge clk);
        rst = 1'b0;
        while (busy && n < 5000) begin
            @(posedge clk); #1;
            n++;
            LRULineReady = (init_drop && n == 10);
        end
        LRULineReady = 1'b0;
        chk("init_busy_len", n, 2048);
    endtask

    typedef struct {
        logic [16:0] tag;
        logic [10:0] idx;
        logic        ls;
        logic        exp_hit;
        logic        exp_evict;
        logic        exp_wb;
    } vec_t;

    vec_t vecs [19];

    initial begin
        logic [31:0] ev0, wb0;
        int n;

        vecs[0]  = '{17'h00001, 11'd5,    1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{17'h00001, 11'd5,    1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{17'h0000A, 11'd7,    1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{17'h0000B, 11'd7,    1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{17'h0000C, 11'd7,    1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{17'h0000D, 11'd7,    1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{17'h0000A, 11'd7,    1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{17'h0000E, 11'd7,    1'b0, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{17'h0000B, 11'd7,    1'b0, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{17'h0000A, 11'd7,    1'b0, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{17'h0001F, 11'd3,    1'b1, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{17'h00020, 11'd3,    1'b0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{17'h00021, 11'd3,    1'b0, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{17'h00022, 11'd3,    1'b0, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{17'h00023, 11'd3,    1'b0, 1'b0, 1'b1, 1'b1};
        vecs[15] = '{17'h00055, 11'd0,    1'b0, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{17'h00055, 11'd2047, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{17'h00055, 11'd0,    1'b0, 1'b1, 1'b0, 1'b0};
        vecs[18] = '{17'h00055, 11'd2047, 1'b0, 1'b1, 1'b0, 1'b0};

        rst = 1'b1; LRULineReady = 1'b0; LRUTag = '0; LRUIndex = '0; LRULoadStore = 1'b0;
        s_rst = 1'b1; s_rdy = 1'b0; s_tag = '0; s_idx = '0; s_ls = 1'b0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b1);
        chk("rst_rv", resultValid, 1'b0);
        chk("rst_lastHit", lastHit, 1'b0);
        chk_counters("rst");
        release_reset(1'b0);

        for (int i = 0; i < 19; i++) begin
            ev0 = evictCount;
            wb0 = writebackCount;
            access(vecs[i].tag, vecs[i].idx, vecs[i].ls, 1'b0);
            chk($sformatf("vec%0d.hit", i), lastHit, vecs[i].exp_hit);
            chk($sformatf("vec%0d.evict", i), evictCount - ev0, vecs[i].exp_evict);
            chk($sformatf("vec%0d.wb", i), writebackCount - wb0, vecs[i].exp_wb);
        end
        chk("tbl.hit", hitCount, 5);
        chk("tbl.miss", missCount, 14);
        chk("tbl.load", loadCount, 18);
        chk("tbl.store", storeCount, 1);
        chk("tbl.evict", evictCount, 3);
        chk("tbl.wb", writebackCount, 1);

        // Second request while busy is dropped and leaves no cache state behind
        access(17'h00033, 11'd9, 1'b0, 1'b1);
        chk("drop.drop", dropCount, 1);
        chk("drop.miss", missCount, 15);
        chk("drop.load", loadCount, 19);
        chk("drop.hit", hitCount, 5);
        access(17'h00032, 11'd9, 1'b0, 1'b0);
        chk("drop.not_cached", lastHit, 1'b0);

        access(17'h00055, 11'd0, 1'b0, 1'b0);
        chk("pre_abort_hit", lastHit, 1'b1);

        // Reset while the access sits in COMPARE
        @(negedge clk);
        LRUTag = 17'h00001; LRUIndex = 11'd5; LRULoadStore = 1'b0; LRULineReady = 1'b1;
        @(posedge clk); #1;
        LRULineReady = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_rv", resultValid, 1'b0);
        chk("abort_busy", busy, 1'b1);
        chk("abort_lastHit", lastHit, 1'b0);
        model_reset();
        chk_counters("abort");
        release_reset(1'b1);
        m_drop = 1;
        chk("init_drop", dropCount, 1);
        access(17'h00001, 11'd5, 1'b0, 1'b0);
        chk("reaccess_miss", lastHit, 1'b0);

        for (int i = 0; i < 400; i++) begin
            logic [10:0] ridx;
            case ($urandom_range(0, 4))
                0:       ridx = 11'd0;
                1:       ridx = 11'd2047;
                2:       ridx = 11'd5;
                3:       ridx = 11'($urandom_range(0, 2047));
                default: ridx = 11'd13;
            endcase
            access(17'($urandom_range(0, 6)), ridx, 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 7) == 0));
        end

        // Narrow instance: counters saturate at 3
        @(negedge clk);
        s_rst = 1'b0;
        n = 0;
        while (s_busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("sat.init_len", n, 4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            s_tag = 4'd3; s_idx = 2'd1; s_ls = 1'b0; s_rdy = 1'b1;
            @(posedge clk); #1;
            s_rdy = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            chk("sat.idle", s_busy, 1'b0);
        end
        chk("sat.hit", s_hit, 3);
        chk("sat.miss", s_miss, 1);
        chk("sat.load", s_load, 3);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            s_ls = 1'b1; s_rdy = 1'b1;
            repeat (4) @(posedge clk);
            #1;
            s_rdy = 1'b0;
            @(posedge clk); #1;
        end
        chk("sat.drop", s_drop, 3);
        chk("sat.store", s_store, 2);
        chk("sat.hit2", s_hit, 3);
        chk("sat.last", s_last, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
